// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - subtractive greatest-common-divisor engine
module gcd_engine #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     io_a,
  input  logic [W-1:0]     io_b,
  input  logic             io_e,
  output logic [W-1:0]     io_z,
  output logic             io_v,
  output logic             io_busy,
  output logic [CNT_W-1:0] io_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     z_q, z_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] cycles_inc;

  // The step counter sticks at its maximum rather than wrapping.
  assign cycles_inc = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      v_q      <= v_d;
      busy_q   <= busy_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    v_d      = v_q;
    busy_d   = busy_q;
    cycles_d = cycles_q;

    // A load restarts from any state and pre-empts a step or a publish.
    if (io_e) begin
      x_d      = io_a;
      y_d      = io_b;
      cycles_d = '0;
      v_d      = 1'b0;
      busy_d   = 1'b1;
      state_d  = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (y_q == '0) begin
            z_d     = x_q;
            v_d     = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else if (x_q == '0) begin
            x_d      = y_q;
            y_d      = '0;
            cycles_d = cycles_inc;
          end else if (x_q > y_q) begin
            x_d      = x_q - y_q;
            cycles_d = cycles_inc;
          end else begin
            y_d      = y_q - x_q;
            cycles_d = cycles_inc;
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign io_z      = z_q;
  assign io_v      = v_q;
  assign io_busy   = busy_q;
  assign io_cycles = cycles_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - directed self-checking bench for gcd_engine
module tb_gcd_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] io_a;
  logic [15:0] io_b;
  logic        io_e;
  logic [15:0] io_z;
  logic        io_v;
  logic        io_busy;
  logic [15:0] io_cycles;
  logic [15:0] z8;
  logic        v8;
  logic        busy8;
  logic [7:0]  cycles8;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  gcd_engine #(.W(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .io_a(io_a), .io_b(io_b), .io_e(io_e),
    .io_z(io_z), .io_v(io_v), .io_busy(io_busy), .io_cycles(io_cycles)
  );

  // Narrow-counter copy sees identical stimulus; only its counter is checked.
  gcd_engine #(.W(16), .CNT_W(8)) dut8 (
    .clock(clock), .reset(reset), .io_a(io_a), .io_b(io_b), .io_e(io_e),
    .io_z(z8), .io_v(v8), .io_busy(busy8), .io_cycles(cycles8)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b);
    io_a = a;
    io_b = b;
    io_e = 1'b1;
    tick();
    io_e = 1'b0;
  endtask

  task automatic wait_valid(input int max_edges, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_edges; i++) begin
      tick();
      if (io_v === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_a  = 16'd12;
    io_b  = 16'd8;
    io_e  = 1'b1;
    tick();
    tick();
    total++; if (io_z !== 16'd0) begin bad++; $display("FAIL reset_z got=%0d want=0", io_z); end
    total++; if (io_v !== 1'b0) begin bad++; $display("FAIL reset_v got=%0b want=0", io_v); end
    total++; if (io_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", io_busy); end
    total++; if (io_cycles !== 16'd0) begin bad++; $display("FAIL reset_cycles got=%0d want=0", io_cycles); end
    reset = 1'b0;
    io_e  = 1'b0;
    tick();
    total++; if (io_busy !== 1'b0 || io_v !== 1'b0) begin bad++; $display("FAIL idle_hold busy=%0b v=%0b want=0/0", io_busy, io_v); end
  endtask

  task automatic test_basic();
    load(16'd12, 16'd8);
    total++; if (io_busy !== 1'b1 || io_v !== 1'b0) begin bad++; $display("FAIL basic_start busy=%0b v=%0b want=1/0", io_busy, io_v); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (io_v !== 1'b0) begin bad++; $display("FAIL basic_early_v edge=%0d got=%0b want=0", i, io_v); end
    end
    tick();
    total++; if (io_v !== 1'b1) begin bad++; $display("FAIL basic_v got=%0b want=1", io_v); end
    total++; if (io_z !== 16'd4) begin bad++; $display("FAIL basic_z got=%0d want=4", io_z); end
    total++; if (io_cycles !== 16'd3) begin bad++; $display("FAIL basic_cycles got=%0d want=3", io_cycles); end
    total++; if (io_busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%0b want=0", io_busy); end
    tick(); tick(); tick();
    total++; if (io_v !== 1'b1 || io_z !== 16'd4 || io_cycles !== 16'd3)
      begin bad++; $display("FAIL basic_hold v=%0b z=%0d cycles=%0d want=1/4/3", io_v, io_z, io_cycles); end
  endtask

  task automatic test_b_zero();
    load(16'd7, 16'd0);
    total++; if (io_v !== 1'b0) begin bad++; $display("FAIL bzero_load_v got=%0b want=0", io_v); end
    tick();
    total++; if (io_v !== 1'b1 || io_z !== 16'd7 || io_cycles !== 16'd0)
      begin bad++; $display("FAIL bzero v=%0b z=%0d cycles=%0d want=1/7/0", io_v, io_z, io_cycles); end
  endtask

  task automatic test_swap_and_zero();
    load(16'd0, 16'd5);
    tick();
    total++; if (io_v !== 1'b0 || io_cycles !== 16'd1)
      begin bad++; $display("FAIL swap_step v=%0b cycles=%0d want=0/1", io_v, io_cycles); end
    tick();
    total++; if (io_v !== 1'b1 || io_z !== 16'd5 || io_cycles !== 16'd1)
      begin bad++; $display("FAIL swap_done v=%0b z=%0d cycles=%0d want=1/5/1", io_v, io_z, io_cycles); end
    load(16'd0, 16'd0);
    tick();
    total++; if (io_v !== 1'b1 || io_z !== 16'd0 || io_cycles !== 16'd0)
      begin bad++; $display("FAIL zero_zero v=%0b z=%0d cycles=%0d want=1/0/0", io_v, io_z, io_cycles); end
  endtask

  task automatic test_reload();
    bit ok;
    load(16'd48, 16'd18);
    tick();
    total++; if (io_v !== 1'b0) begin bad++; $display("FAIL reload_mid_v got=%0b want=0", io_v); end
    load(16'd9, 16'd6);
    total++; if (io_v !== 1'b0 || io_cycles !== 16'd0)
      begin bad++; $display("FAIL reload_restart v=%0b cycles=%0d want=0/0", io_v, io_cycles); end
    wait_valid(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL reload_timeout got=no_valid want=valid"); end
    total++; if (io_z !== 16'd3 || io_cycles !== 16'd3)
      begin bad++; $display("FAIL reload_result z=%0d cycles=%0d want=3/3", io_z, io_cycles); end
  endtask

  task automatic test_hold_load();
    bit ok;
    io_a = 16'd12;
    io_b = 16'd8;
    io_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (io_busy !== 1'b1 || io_cycles !== 16'd0 || io_v !== 1'b0)
        begin bad++; $display("FAIL hold_load busy=%0b cycles=%0d v=%0b want=1/0/0", io_busy, io_cycles, io_v); end
    end
    io_e = 1'b0;
    wait_valid(20, ok);
    total++; if (!ok || io_z !== 16'd4 || io_cycles !== 16'd3)
      begin bad++; $display("FAIL hold_result ok=%0b z=%0d cycles=%0d want=1/4/3", ok, io_z, io_cycles); end
  endtask

  task automatic test_back_to_back();
    load(16'd12, 16'd8);
    tick(); tick(); tick();
    load(16'd7, 16'd0);
    total++; if (io_v !== 1'b0 || io_busy !== 1'b1)
      begin bad++; $display("FAIL b2b_publish_edge v=%0b busy=%0b want=0/1", io_v, io_busy); end
    tick();
    total++; if (io_v !== 1'b1 || io_z !== 16'd7)
      begin bad++; $display("FAIL b2b_result v=%0b z=%0d want=1/7", io_v, io_z); end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    load(16'd100, 16'd75);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (io_z !== 16'd0 || io_v !== 1'b0 || io_busy !== 1'b0 || io_cycles !== 16'd0)
      begin bad++; $display("FAIL midrun_reset z=%0d v=%0b busy=%0b cycles=%0d want=0/0/0/0", io_z, io_v, io_busy, io_cycles); end
    tick(); tick(); tick();
    total++; if (io_v !== 1'b0 || io_busy !== 1'b0)
      begin bad++; $display("FAIL midrun_idle v=%0b busy=%0b want=0/0", io_v, io_busy); end
    load(16'd100, 16'd75);
    wait_valid(20, ok);
    total++; if (!ok || io_z !== 16'd25 || io_cycles !== 16'd4)
      begin bad++; $display("FAIL midrun_result ok=%0b z=%0d cycles=%0d want=1/25/4", ok, io_z, io_cycles); end
  endtask

  task automatic test_saturation();
    bit ok;
    int busy_drop;
    busy_drop = 0;
    ok = 1'b0;
    load(16'hFFFF, 16'd1);
    for (int i = 0; i < 70000; i++) begin
      if (io_v === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (io_busy !== 1'b1) busy_drop++;
      tick();
    end
    total++; if (!ok) begin bad++; $display("FAIL sat_timeout got=no_valid want=valid"); end
    total++; if (busy_drop != 0) begin bad++; $display("FAIL sat_busy drops=%0d want=0", busy_drop); end
    total++; if (io_z !== 16'd1 || io_cycles !== 16'd65535)
      begin bad++; $display("FAIL sat_result16 z=%0d cycles=%0d want=1/65535", io_z, io_cycles); end
    total++; if (v8 !== 1'b1 || z8 !== 16'd1 || cycles8 !== 8'd255)
      begin bad++; $display("FAIL sat_result8 v=%0b z=%0d cycles=%0d want=1/1/255", v8, z8, cycles8); end
  endtask

  initial begin
    reset = 1'b1;
    io_a  = '0;
    io_b  = '0;
    io_e  = 1'b0;
    test_reset();
    test_basic();
    test_b_zero();
    test_swap_and_zero();
    test_reload();
    test_hold_load();
    test_back_to_back();
    test_reset_midrun();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
